// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: register constants, destination-tag struct,
// mul/div tracker state encoding and a tag builder that masks writes to $0.
package mips_pipe_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic       wr_en;
        logic [4:0] wr_addr;
        logic       is_load;
    } dest_tag_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam dest_tag_t NOP_TAG = '{wr_en: 1'b0, wr_addr: REG_ZERO, is_load: 1'b0};

    // $0 is hard-wired, so a write to it never becomes a live tag
    function automatic dest_tag_t make_tag(input logic wr_en, input logic [4:0] wr_addr,
                                           input logic is_load);
        dest_tag_t t;
        t.wr_en   = wr_en && (wr_addr != REG_ZERO);
        t.wr_addr = wr_addr;
        t.is_load = is_load;
        return t;
    endfunction

endpackage

// File: rtl/mips_md_busy_tracker.sv
// Occupancy tracker for the multi-cycle multiply/divide unit: IDLE/BUSY FSM
// with a down-counter loaded from the per-operation latency.
module mips_md_busy_tracker
    import mips_pipe_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_mult,
    input  logic start_div,
    output logic busy
);

    localparam logic [3:0] MULT_INIT = 4'(MULT_LAT - 1);
    localparam logic [3:0] DIV_INIT  = 4'(DIV_LAT - 1);

    md_state_t  state;
    logic [3:0] cnt;

    // BUSY lasts LAT-1 cycles: leave on the cycle the counter steps down to 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start_mult || start_div) begin
                        state <= MD_BUSY;
                        busy  <= 1'b1;
                        cnt   <= start_mult ? MULT_INIT : DIV_INIT;
                    end
                end
                MD_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_hazard_ctrl.sv
// ID-stage hazard control: EX/MEM/WB destination-tag pipeline plus load-use and
// HI/LO interlocks. Define HAZ_PERF_CNT_EN to add saturating stall/flush counters.
module mips_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 12
`ifdef HAZ_PERF_CNT_EN
   ,parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_wr_en,
    input  logic [4:0] id_wr_addr,
    input  logic       id_is_load,
    input  logic       id_is_mult,
    input  logic       id_is_div,
    input  logic       id_uses_hilo,
    input  logic       flush,
    output logic       stall,
    output logic       bubble,
    output logic       ex_wr_en,
    output logic [4:0] ex_wr_addr,
    output logic       mem_wr_en,
    output logic [4:0] mem_wr_addr,
    output logic       wb_wr_en,
    output logic [4:0] wb_wr_addr,
    output logic       ex_is_load,
    output logic       md_busy
`ifdef HAZ_PERF_CNT_EN
   ,output logic [CNT_W-1:0] perf_lu_stalls,
    output logic [CNT_W-1:0] perf_md_stalls,
    output logic [CNT_W-1:0] perf_flushes
`endif
);

    dest_tag_t ex_tag, mem_tag, wb_tag;
    logic      lu_hazard, md_hazard, issue;

    assign lu_hazard = ex_tag.is_load && ex_tag.wr_en && id_valid &&
                       ((id_uses_rs && (id_rs == ex_tag.wr_addr)) ||
                        (id_uses_rt && (id_rt == ex_tag.wr_addr)));
    assign md_hazard = md_busy && id_valid && (id_uses_hilo || id_is_mult || id_is_div);

    // flush overrides both interlocks; a squashed instruction never issues
    assign stall  = (lu_hazard || md_hazard) && !flush;
    assign bubble = stall;
    assign issue  = id_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_tag  <= NOP_TAG;
            mem_tag <= NOP_TAG;
            wb_tag  <= NOP_TAG;
        end else begin
            ex_tag  <= issue ? make_tag(id_wr_en, id_wr_addr, id_is_load) : NOP_TAG;
            mem_tag <= ex_tag;
            wb_tag  <= mem_tag;
        end
    end

    assign ex_wr_en    = ex_tag.wr_en;
    assign ex_wr_addr  = ex_tag.wr_addr;
    assign ex_is_load  = ex_tag.is_load;
    assign mem_wr_en   = mem_tag.wr_en;
    assign mem_wr_addr = mem_tag.wr_addr;
    assign wb_wr_en    = wb_tag.wr_en;
    assign wb_wr_addr  = wb_tag.wr_addr;

    mips_md_busy_tracker #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_mult (issue && id_is_mult),
        .start_div  (issue && id_is_div && !id_is_mult),
        .busy       (md_busy)
    );

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_lu_stalls <= '0;
            perf_md_stalls <= '0;
            perf_flushes   <= '0;
        end else begin
            if (lu_hazard && !flush && (perf_lu_stalls != '1))
                perf_lu_stalls <= perf_lu_stalls + 1'b1;
            if (md_hazard && !flush && (perf_md_stalls != '1))
                perf_md_stalls <= perf_md_stalls + 1'b1;
            if (flush && (perf_flushes != '1))
                perf_flushes <= perf_flushes + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Scoreboard bench for mips_hazard_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares. Honours HAZ_PERF_CNT_EN.
module tb_mips_hazard_ctrl;
    import mips_pipe_pkg::*;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       wr;
        logic [4:0] wa;
        logic       load;
        logic       mult;
        logic       div;
        logic       hilo;
    } id_t;

    typedef struct packed {
        logic       stall;
        logic       ex_en;
        logic [4:0] ex_a;
        logic       mem_en;
        logic [4:0] mem_a;
        logic       wb_en;
        logic [4:0] wb_a;
        logic       ld;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load;
    logic id_is_mult, id_is_div, id_uses_hilo, flush;
    logic [4:0] id_rs, id_rt, id_wr_addr;
    logic stall, bubble, ex_wr_en, mem_wr_en, wb_wr_en, ex_is_load, md_busy;
    logic [4:0] ex_wr_addr, mem_wr_addr, wb_wr_addr;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_lu_stalls, perf_md_stalls, perf_flushes;
`endif

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mips_hazard_ctrl #(
        .MULT_LAT (4),
        .DIV_LAT  (12)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_wr_en     (id_wr_en),
        .id_wr_addr   (id_wr_addr),
        .id_is_load   (id_is_load),
        .id_is_mult   (id_is_mult),
        .id_is_div    (id_is_div),
        .id_uses_hilo (id_uses_hilo),
        .flush        (flush),
        .stall        (stall),
        .bubble       (bubble),
        .ex_wr_en     (ex_wr_en),
        .ex_wr_addr   (ex_wr_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .wb_wr_en     (wb_wr_en),
        .wb_wr_addr   (wb_wr_addr),
        .ex_is_load   (ex_is_load),
        .md_busy      (md_busy)
`ifdef HAZ_PERF_CNT_EN
       ,.perf_lu_stalls (perf_lu_stalls),
        .perf_md_stalls (perf_md_stalls),
        .perf_flushes   (perf_flushes)
`endif
    );

    function automatic exp_t E(input logic s, input logic xe, input logic [4:0] xa,
                               input logic me, input logic [4:0] ma,
                               input logic we, input logic [4:0] wa,
                               input logic ld, input logic bz);
        exp_t e;
        e = '{stall: s, ex_en: xe, ex_a: xa, mem_en: me, mem_a: ma,
              wb_en: we, wb_a: wa, ld: ld, busy: bz};
        return e;
    endfunction

    function automatic id_t nop();
        id_t i;
        i = '0;
        return i;
    endfunction

    function automatic id_t lw(input logic [4:0] d);
        id_t i;
        i = '0; i.valid = 1'b1; i.rs = 5'd29; i.urs = 1'b1;
        i.wr = 1'b1; i.wa = d; i.load = 1'b1;
        return i;
    endfunction

    function automatic id_t add(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        id_t i;
        i = '0; i.valid = 1'b1; i.rs = s; i.rt = t; i.urs = 1'b1; i.urt = 1'b1;
        i.wr = 1'b1; i.wa = d;
        return i;
    endfunction

    function automatic id_t md(input logic is_mult);
        id_t i;
        i = '0; i.valid = 1'b1; i.rs = 5'd4; i.rt = 5'd5; i.urs = 1'b1; i.urt = 1'b1;
        i.mult = is_mult; i.div = !is_mult;
        return i;
    endfunction

    function automatic id_t mf(input logic [4:0] d);
        id_t i;
        i = '0; i.valid = 1'b1; i.hilo = 1'b1; i.wr = 1'b1; i.wa = d;
        return i;
    endfunction

    task automatic step(input logic rst, input id_t i, input logic fl, input exp_t e);
        rst_n = rst;
        id_valid = i.valid; id_rs = i.rs; id_rt = i.rt;
        id_uses_rs = i.urs; id_uses_rt = i.urt;
        id_wr_en = i.wr; id_wr_addr = i.wa; id_is_load = i.load;
        id_is_mult = i.mult; id_is_div = i.div; id_uses_hilo = i.hilo;
        flush = fl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic chk_perf(input int lu, input int mdc, input int fl);
        checks++;
        if (perf_lu_stalls != 32'(lu) || perf_md_stalls != 32'(mdc) || perf_flushes != 32'(fl)) begin
            failures++;
            $display("FAIL perf_counters cyc=%0d actual lu=%0d md=%0d fl=%0d required lu=%0d md=%0d fl=%0d",
                     cyc, perf_lu_stalls, perf_md_stalls, perf_flushes, lu, mdc, fl);
        end
    endtask
`endif

    // monitor: outputs are valid every cycle, compared mid-cycle
    initial begin
        exp_t e, act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = '{stall: stall, ex_en: ex_wr_en, ex_a: ex_wr_addr, mem_en: mem_wr_en,
                        mem_a: mem_wr_addr, wb_en: wb_wr_en, wb_a: wb_wr_addr,
                        ld: ex_is_load, busy: md_busy};
                checks++;
                if (act !== e) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d actual stall/ex/mem/wb/ld/busy=%b required=%b",
                             cyc, act, e);
                end
                checks++;
                if (bubble !== e.stall) begin
                    failures++;
                    $display("FAIL bubble cyc=%0d actual=%b required=%b", cyc, bubble, e.stall);
                end
            end
        end
    end

    initial begin
        id_t j;
        rst_n = 1'b0;
        {id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load} = '0;
        {id_is_mult, id_is_div, id_uses_hilo, flush} = '0;
        {id_rs, id_rt, id_wr_addr} = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        step(1'b0, nop(), 1'b0, E(0, 0,0, 0,0, 0,0, 0,0));

        // LW to $0 then a use of $0: no tag, no stall
        step(1'b1, lw(5'd0),             1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        step(1'b1, add(5'd9,5'd0,5'd0),  1'b0, E(0, 0,0, 0,0, 0,0, 1,0));
        step(1'b1, nop(),                1'b0, E(0, 1,9, 0,0, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 1,9, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 0,0, 1,9, 0,0));

        // DIV then MFLO: 11 stall cycles, MFLO issues when busy falls
        step(1'b1, md(1'b0),             1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        for (int k = 0; k < 11; k++)
            step(1'b1, mf(5'd2),         1'b0, E(1, 0,0, 0,0, 0,0, 0,1));
        step(1'b1, mf(5'd2),             1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 1,2, 0,0, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 1,2, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 0,0, 1,2, 0,0));

        // reset asserted while DIV is busy and MFLO is stalled
        step(1'b1, md(1'b0),             1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        step(1'b1, add(5'd9,5'd1,5'd2),  1'b0, E(0, 0,0, 0,0, 0,0, 0,1));
        step(1'b0, mf(5'd2),             1'b0, E(1, 1,9, 0,0, 0,0, 0,1));
        step(1'b1, mf(5'd3),             1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 1,3, 0,0, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 1,3, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 0,0, 1,3, 0,0));

        // LW $8 then ADD reading rs=8: one-cycle load-use stall
        step(1'b1, lw(5'd8),             1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        step(1'b1, add(5'd9,5'd8,5'd10), 1'b0, E(1, 1,8, 0,0, 0,0, 1,0));
        step(1'b1, add(5'd9,5'd8,5'd10), 1'b0, E(0, 0,0, 1,8, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 1,9, 0,0, 1,8, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 1,9, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 0,0, 1,9, 0,0));

        // MULT then MFHI: 3 stall cycles
        step(1'b1, md(1'b1),             1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        for (int k = 0; k < 3; k++)
            step(1'b1, mf(5'd3),         1'b0, E(1, 0,0, 0,0, 0,0, 0,1));
        step(1'b1, mf(5'd3),             1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 1,3, 0,0, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 1,3, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 0,0, 1,3, 0,0));
`ifdef HAZ_PERF_CNT_EN
        chk_perf(1, 3, 0);
`endif

        // flush beats load-use; flushed MULT never starts the unit
        step(1'b1, lw(5'd8),             1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        step(1'b1, add(5'd9,5'd8,5'd10), 1'b1, E(0, 1,8, 0,0, 0,0, 1,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 1,8, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 0,0, 1,8, 0,0));
        step(1'b1, md(1'b1),             1'b1, E(0, 0,0, 0,0, 0,0, 0,0));
        step(1'b1, mf(5'd3),             1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 1,3, 0,0, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 1,3, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 0,0, 1,3, 0,0));

        // load-use through rt only
        step(1'b1, lw(5'd8),             1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        step(1'b1, add(5'd9,5'd1,5'd8),  1'b0, E(1, 1,8, 0,0, 0,0, 1,0));
        step(1'b1, add(5'd9,5'd1,5'd8),  1'b0, E(0, 0,0, 1,8, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 1,9, 0,0, 1,8, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 1,9, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 0,0, 1,9, 0,0));

        // matching rs/rt fields that are not read do not interlock
        j = '0; j.valid = 1'b1; j.rs = 5'd8; j.rt = 5'd8; j.wr = 1'b1; j.wa = REG_RA;
        step(1'b1, lw(5'd8),             1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        step(1'b1, j,                    1'b0, E(0, 1,8, 0,0, 0,0, 1,0));
        step(1'b1, nop(),                1'b0, E(0, 1,31, 1,8, 0,0, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 1,31, 1,8, 0,0));
        step(1'b1, nop(),                1'b0, E(0, 0,0, 0,0, 1,31, 0,0));
`ifdef HAZ_PERF_CNT_EN
        chk_perf(2, 3, 2);
`endif

        step(1'b1, nop(),                1'b0, E(0, 0,0, 0,0, 0,0, 0,0));
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
